spi_device: RTL and testbench

- SPI slave (device-side) peripheral: the far end of the team's SPI host core. Same register-bus style: addr/wdata/rdata/be/we/re, registered read data, one-cycle interrupt pulse.
- Samples the external sclk, cs_n and sd inputs into the clk_i domain, shifts characters in and out, and buffers one RX and one TX word for software.
- Sits on the peripheral bus next to the SPI host; it lets the SoC act as a target for an off-chip SPI master.

---
 rtl/spi_device.sv | 257 +++++++++++++++++++++++++
 tb/tb_spi_device.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_device.sv
`default_nettype none
// ============================================================================
// Module   : spi_device
// Brief    : SPI target peripheral. Synchronises sclk/cs_n/sd into clk_i,
//            shifts characters in and out, and buffers one RX and one TX word
//            behind a simple addr/wdata/rdata register interface.
// Revision : 1.0 - initial release
// ============================================================================
module spi_device #(
  parameter int MAX_CHAR    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic [3:0]  be_i,
  input  logic        we_i,
  input  logic        re_i,
  output logic        error_o,
  output logic        intr_o,
  input  logic        sclk_i,
  input  logic        cs_ni,
  input  logic        sd_i,
  output logic        sd_o,
  output logic        sd_oe_o
);

  localparam int         IDX_W   = $clog2(MAX_CHAR);
  localparam logic [5:0] MAX_LEN = 6'(MAX_CHAR);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  // Flop state
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [1:0]             state_q, state_d;
  logic                   en_q, en_d, rxneg_q, rxneg_d, txneg_q, txneg_d;
  logic                   lsb_q, lsb_d, ie_q, ie_d;
  logic [4:0]             char_len_q, char_len_d;
  logic [31:0]            txdata_q, txdata_d, rxdata_q, rxdata_d;
  logic                   tx_full_q, tx_full_d, rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d, underrun_q, underrun_d;
  logic [5:0]             bit_cnt_q, bit_cnt_d;
  logic [MAX_CHAR-1:0]    tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   intr_q, intr_d;

  // Combinational helpers
  logic                   sclk_s, cs_s, sd_s;
  logic                   sclk_rise, sclk_fall, cs_fall;
  logic                   sample_edge, drive_edge, abort;
  logic [5:0]             eff_len;
  logic [IDX_W-1:0]       msb_idx;
  logic [2:0]             reg_idx;
  logic                   ctrl_wr, tx_wr, stat_wr, rx_rd;
  logic                   busy, do_load, do_sample, do_drive, char_done, do_abort;
  logic [MAX_CHAR-1:0]    rx_shift_nxt, rx_char, load_word, out_word;
  logic                   unused_addr;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sd_s      = sd_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = cs_prev_q & ~cs_s;

  // Sample on the selected edge, drive on the other one
  assign sample_edge = rxneg_q ? sclk_fall : sclk_rise;
  assign drive_edge  = rxneg_q ? sclk_rise : sclk_fall;
  assign abort       = cs_s | ~en_q;

  // Zero (or anything wider than the shifter) selects the full width
  assign eff_len = ((char_len_q == 5'd0) || ({1'b0, char_len_q} > MAX_LEN)) ?
                   MAX_LEN : {1'b0, char_len_q};
  assign msb_idx = IDX_W'(eff_len - 6'd1);

  assign reg_idx     = addr_i[4:2];
  assign unused_addr = ^{addr_i[7:5], addr_i[1:0]};
  assign ctrl_wr     = we_i && (reg_idx == 3'd0);
  assign tx_wr       = we_i && (reg_idx == 3'd1) && (|be_i);
  assign stat_wr     = we_i && (reg_idx == 3'd3) && be_i[0];
  assign rx_rd       = re_i && (reg_idx == 3'd2);
  assign error_o     = (we_i | re_i) & addr_i[4];

  // LSB-first characters land at the top of the shifter and need realigning
  assign rx_shift_nxt = lsb_q ? {sd_s, rx_shift_q[MAX_CHAR-1:1]}
                              : {rx_shift_q[MAX_CHAR-2:0], sd_s};
  assign rx_char      = lsb_q ? (rx_shift_nxt >> (MAX_LEN - eff_len)) : rx_shift_nxt;

  // During LOAD the pin already shows the word being loaded
  assign load_word = tx_full_q ? txdata_q[MAX_CHAR-1:0] : '0;
  assign out_word  = (state_q == ST_LOAD) ? load_word : tx_shift_q;
  assign sd_oe_o   = ~cs_s & en_q;
  assign sd_o      = sd_oe_o & (lsb_q ? out_word[0] : out_word[msb_idx]);

  assign rdata_o = rdata_q;
  assign intr_o  = intr_q;

  // State register and all datapath flops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sd_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      rxneg_q     <= 1'b0;
      txneg_q     <= 1'b0;
      lsb_q       <= 1'b0;
      ie_q        <= 1'b0;
      char_len_q  <= 5'd0;
      txdata_q    <= 32'd0;
      rxdata_q    <= 32'd0;
      tx_full_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      bit_cnt_q   <= 6'd0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rdata_q     <= 32'd0;
      intr_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      sd_sync_q   <= sd_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      en_q        <= en_d;
      rxneg_q     <= rxneg_d;
      txneg_q     <= txneg_d;
      lsb_q       <= lsb_d;
      ie_q        <= ie_d;
      char_len_q  <= char_len_d;
      txdata_q    <= txdata_d;
      rxdata_q    <= rxdata_d;
      tx_full_q   <= tx_full_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rdata_q     <= rdata_d;
      intr_q      <= intr_d;
    end
  end

  // Next-state logic: a cs_n rise or en clear always returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en_q && cs_fall) state_d = ST_LOAD;
      ST_LOAD:  state_d = abort ? ST_IDLE : ST_SHIFT;
      ST_SHIFT: begin
        if (abort)          state_d = ST_IDLE;
        else if (char_done) state_d = ST_LOAD;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM output strobes
  always_comb begin
    busy      = (state_q != ST_IDLE);
    do_abort  = busy && abort;
    do_load   = (state_q == ST_LOAD) && !abort;
    do_sample = (state_q == ST_SHIFT) && !abort && sample_edge;
    do_drive  = (state_q == ST_SHIFT) && !abort && drive_edge && (bit_cnt_q != 6'd0);
    char_done = do_sample && ((bit_cnt_q + 6'd1) == eff_len);
  end

  // Register file and shifter updates; bus clears first so FSM sets win
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_ni};
    sd_sync_d   = {sd_sync_q[SYNC_STAGES-2:0], sd_i};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    en_d        = en_q;
    rxneg_d     = rxneg_q;
    txneg_d     = txneg_q;
    lsb_d       = lsb_q;
    ie_d        = ie_q;
    char_len_d  = char_len_q;
    txdata_d    = txdata_q;
    rxdata_d    = rxdata_q;
    tx_full_d   = tx_full_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    underrun_d  = underrun_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    intr_d      = 1'b0;

    if (ctrl_wr && !busy) begin
      if (be_i[0]) {ie_d, lsb_d, txneg_d, rxneg_d, en_d} = wdata_i[4:0];
      if (be_i[1]) char_len_d = wdata_i[12:8];
    end
    if (rx_rd) rx_valid_d = 1'b0;
    if (stat_wr) begin
      if (wdata_i[3]) overrun_d  = 1'b0;
      if (wdata_i[4]) underrun_d = 1'b0;
    end

    if (do_abort) begin
      bit_cnt_d  = 6'd0;
      tx_shift_d = '0;
      rx_shift_d = '0;
    end
    if (do_load) begin
      tx_shift_d = load_word;
      tx_full_d  = 1'b0;
      if (!tx_full_q) underrun_d = 1'b1;
      bit_cnt_d  = 6'd0;
      rx_shift_d = '0;
    end
    if (do_sample) begin
      rx_shift_d = rx_shift_nxt;
      bit_cnt_d  = bit_cnt_q + 6'd1;
    end
    if (char_done) begin
      rxdata_d   = 32'(rx_char);
      if (rx_valid_q && !rx_rd) overrun_d = 1'b1;
      rx_valid_d = 1'b1;
      intr_d     = ie_q;
    end
    if (do_drive) tx_shift_d = lsb_q ? (tx_shift_q >> 1) : (tx_shift_q << 1);

    if (tx_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) txdata_d[8*b +: 8] = wdata_i[8*b +: 8];
      end
      tx_full_d = 1'b1;
    end

    case (reg_idx)
      3'd0:    rdata_d = {19'd0, char_len_q, 3'd0, ie_q, lsb_q, txneg_q, rxneg_q, en_q};
      3'd2:    rdata_d = rxdata_q;
      3'd3:    rdata_d = {27'd0, underrun_q, overrun_q, busy, tx_full_q, rx_valid_q};
      default: rdata_d = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_device.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_device
// Brief    : Randomised bench for spi_device with an SPI master model, a
//            register-level reference model and a read-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_device;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic [3:0]  be_i = '0;
  logic        we_i = 1'b0, re_i = 1'b0;
  logic        error_o, intr_o;
  logic        sclk = 1'b0, cs_n = 1'b1, sd_in = 1'b0;
  logic        sd_o, sd_oe_o;

  always #5 clk = ~clk;

  spi_device #(.MAX_CHAR(32), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .be_i(be_i), .we_i(we_i), .re_i(re_i),
    .error_o(error_o), .intr_o(intr_o), .sclk_i(sclk), .cs_ni(cs_n),
    .sd_i(sd_in), .sd_o(sd_o), .sd_oe_o(sd_oe_o)
  );

  int checks = 0;
  int failures = 0;
  int intr_cnt = 0;

  // Reference model of the software-visible state
  logic [31:0] m_ctrl = '0, m_txdata = '0, m_rxdata = '0;
  logic        m_tx_full = 0, m_rx_valid = 0, m_overrun = 0, m_underrun = 0;

  // Scoreboard of pending register reads
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_pend = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a[4:2])
      3'd0:    return m_ctrl;
      3'd2:    return m_rxdata;
      3'd3:    return {27'd0, m_underrun, m_overrun, 1'b0, m_tx_full, m_rx_valid};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) rd_pend <= re_i;

  // Monitor: every read returns data one cycle later
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read actual=0x%0h required=none", rdata_o);
      end else begin
        logic [31:0] e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, {32'd0, rdata_o}, {32'd0, e});
      end
    end
  end

  always @(negedge clk) if (intr_o === 1'b1) intr_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    addr_i = a; wdata_i = d; be_i = 4'hF; we_i = 1'b1;
    @(negedge clk);
    we_i = 1'b0; be_i = 4'h0;
  endtask

  task automatic write_ctrl(input logic [31:0] d);
    bus_write(8'h00, d);
    m_ctrl = d & 32'h0000_1F1F;
  endtask

  task automatic write_tx(input logic [31:0] d);
    bus_write(8'h04, d);
    m_txdata = d;
    m_tx_full = 1'b1;
  endtask

  task automatic w1c(input logic [31:0] d);
    bus_write(8'h0C, d);
    if (d[3]) m_overrun = 1'b0;
    if (d[4]) m_underrun = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input string name);
    exp_q.push_back(model_read(a));
    name_q.push_back(name);
    @(negedge clk);
    addr_i = a; re_i = 1'b1;
    if (a[4:2] == 3'd2) m_rx_valid = 1'b0;
    @(negedge clk);
    re_i = 1'b0;
  endtask

  // SPI master, CPOL=0; neg=1 samples on falling sclk and drives on rising
  task automatic spi_frame(input bit neg, input int nbits, input logic [63:0] mosi,
                           output logic [63:0] miso);
    miso = '0;
    @(negedge clk);
    cs_n = 1'b0; sclk = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (!neg) begin
        sd_in = mosi[i];
        repeat (4) @(negedge clk);
        miso[i] = sd_o;
        sclk = 1'b1;
        repeat (8) @(negedge clk);
        sclk = 1'b0;
        repeat (4) @(negedge clk);
      end else begin
        sclk = 1'b1;
        @(negedge clk);
        sd_in = mosi[i];
        repeat (7) @(negedge clk);
        miso[i] = sd_o;
        sclk = 1'b0;
        repeat (8) @(negedge clk);
      end
    end
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // One cs_n frame of nfull whole characters plus extra bits of a partial one.
  // Every character start loads TXDATA, including the one that begins right
  // after the last completed character.
  task automatic do_frame(input int nfull, input int extra, input logic [31:0] c0,
                          input logic [31:0] c1, input string tag);
    int          L, nbits, nload, base;
    bit          lsb, neg, ie;
    logic [31:0] ch[2];
    logic [31:0] txv[3];
    logic [31:0] mask;
    logic [63:0] mosi, miso_exp, miso_act;
    L    = (m_ctrl[12:8] == 5'd0) ? 32 : int'(m_ctrl[12:8]);
    lsb  = m_ctrl[3]; neg = m_ctrl[1]; ie = m_ctrl[4];
    mask = 32'((64'h1 << L) - 64'h1);
    ch[0] = c0 & mask; ch[1] = c1 & mask;
    nbits = nfull * L + extra;
    nload = nfull + 1;
    for (int k = 0; k < nload; k++) begin
      if (m_tx_full) begin txv[k] = m_txdata & mask; m_tx_full = 1'b0; end
      else begin txv[k] = 32'd0; m_underrun = 1'b1; end
    end
    mosi = '0; miso_exp = '0;
    for (int p = 0; p < nbits; p++) begin
      int k, j;
      k = p / L; j = p % L;
      mosi[p]     = lsb ? ch[k][j]  : ch[k][L-1-j];
      miso_exp[p] = lsb ? txv[k][j] : txv[k][L-1-j];
    end
    for (int k = 0; k < nfull; k++) begin
      if (m_rx_valid) m_overrun = 1'b1;
      m_rxdata = ch[k];
      m_rx_valid = 1'b1;
    end
    base = intr_cnt;
    spi_frame(neg, nbits, mosi, miso_act);
    check({tag, "_miso"}, miso_act, miso_exp);
    check({tag, "_intr"}, 64'(intr_cnt - base), ie ? 64'(nfull) : 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rdata", {32'd0, rdata_o}, 64'd0);
    check("rst_intr", {63'd0, intr_o}, 64'd0);
    check("rst_sd_oe", {63'd0, sd_oe_o}, 64'd0);
    check("rst_sd_o", {63'd0, sd_o}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(8'h00, "rst_ctrl");
    bus_read(8'h0C, "rst_status");
    bus_read(8'h08, "rst_rxdata");

    // Mode 0, 8-bit, MSB first
    write_ctrl(32'h0801);
    write_tx(32'hA5);
    bus_read(8'h0C, "t1_status_pre");
    do_frame(1, 0, 32'h3C, 0, "t1");
    bus_read(8'h0C, "t1_status");
    bus_read(8'h08, "t1_rxdata");
    bus_read(8'h04, "t1_txdata_reads0");
    w1c(32'h18);

    // 32-bit LSB first with interrupt
    write_ctrl(32'h0019);
    write_tx($urandom);
    do_frame(1, 0, 32'hDEADBEEF, 0, "t2");
    bus_read(8'h08, "t2_rxdata");

    // Two characters in one frame -> overrun
    write_ctrl(32'h0801);
    write_tx(32'h5A);
    do_frame(2, 0, 32'h12, 32'h34, "t3");
    bus_read(8'h0C, "t3_status");
    bus_read(8'h08, "t3_rxdata");
    w1c(32'h08);
    bus_read(8'h0C, "t3_status_w1c");

    // No TXDATA -> underrun, zeros on MISO
    w1c(32'h18);
    do_frame(1, 0, 32'h77, 0, "t4");
    bus_read(8'h0C, "t4_status");

    // Abort after 5 of 8 bits, then a clean frame
    write_ctrl(32'h0811);
    bus_read(8'h08, "t5_clear");
    do_frame(0, 5, 32'h55, 0, "t5a");
    bus_read(8'h0C, "t5a_status");
    do_frame(1, 0, 32'hC3, 0, "t5b");
    bus_read(8'h08, "t5b_rxdata");

    // Randomised frames
    for (int it = 0; it < 14; it++) begin
      int len, L, nfull, extra;
      logic [31:0] ctrl;
      len   = ($urandom % 4 == 0) ? 0 : int'($urandom_range(8, 31));
      L     = (len == 0) ? 32 : len;
      ctrl  = 32'h1 | (($urandom % 2) << 1) | (($urandom % 2) << 2) |
              (($urandom % 2) << 3) | (($urandom % 2) << 4) | (32'(len) << 8);
      write_ctrl(ctrl);
      bus_read(8'h00, "rnd_ctrl");
      if ($urandom % 2) write_tx($urandom);
      nfull = int'($urandom_range(1, 2));
      extra = (nfull == 1 && ($urandom % 4 == 0)) ? int'($urandom_range(1, L - 1)) : 0;
      do_frame(nfull, extra, $urandom, $urandom, "rnd");
      bus_read(8'h0C, "rnd_status");
      if ($urandom % 2) bus_read(8'h08, "rnd_rxdata");
      if ($urandom % 2) w1c($urandom & 32'h18);
    end

    // Unmapped offsets
    exp_q.push_back(32'd0);
    name_q.push_back("t6_unmapped_rdata");
    @(negedge clk);
    addr_i = 8'h14; re_i = 1'b1;
    #1 check("t6_error_rd", {63'd0, error_o}, 64'd1);
    @(negedge clk);
    re_i = 1'b0;
    #1 check("t6_error_idle", {63'd0, error_o}, 64'd0);
    @(negedge clk);
    addr_i = 8'h18; wdata_i = 32'hFFFF_FFFF; be_i = 4'hF; we_i = 1'b1;
    #1 check("t6_error_wr", {63'd0, error_o}, 64'd1);
    @(negedge clk);
    we_i = 1'b0; be_i = 4'h0;

    // Asynchronous reset in the middle of a frame
    write_ctrl(32'h0801);
    write_tx(32'hFF);
    @(negedge clk);
    addr_i = 8'h00;
    cs_n = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_oe_active", {63'd0, sd_oe_o}, 64'd1);
    check("t6_sd_first_bit", {63'd0, sd_o}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_oe_async", {63'd0, sd_oe_o}, 64'd0);
    check("t6_sd_async", {63'd0, sd_o}, 64'd0);
    check("t6_rdata_async", {32'd0, rdata_o}, 64'd0);
    m_ctrl = '0; m_txdata = '0; m_rxdata = '0;
    m_tx_full = 0; m_rx_valid = 0; m_overrun = 0; m_underrun = 0;
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(8'h00, "t6_ctrl_after_rst");
    bus_read(8'h0C, "t6_status_after_rst");
    bus_read(8'h08, "t6_rxdata_after_rst");

    repeat (5) @(negedge clk);
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
